// File: rtl/morra_pkg.sv
// Shared move/result encodings, FSM states and the forbidden-move payload.
package morra_pkg;

   localparam logic [1:0] MOSSA_NULLA  = 2'b00;
   localparam logic [1:0] SASSO        = 2'b01;
   localparam logic [1:0] CARTA        = 2'b10;
   localparam logic [1:0] FORBICE      = 2'b11;

   localparam logic [1:0] RIS_NULLO    = 2'b00;
   localparam logic [1:0] RIS_PRIMO    = 2'b01;
   localparam logic [1:0] RIS_SECONDO  = 2'b10;
   localparam logic [1:0] RIS_PAREGGIO = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      DONE = 2'b10
   } state_t;

   // Move the last winner may not replay; p2 selects which player it binds.
   typedef struct packed {
      logic       valid;
      logic       p2;
      logic [1:0] mossa;
   } vietata_t;

   // True when move a beats move b.
   function automatic logic batte(input logic [1:0] a, input logic [1:0] b);
      return ((a == SASSO)   && (b == FORBICE)) ||
             ((a == FORBICE) && (b == CARTA))   ||
             ((a == CARTA)   && (b == SASSO));
   endfunction

endpackage

// File: rtl/morra_manche_judge.sv
// Combinational judge of a single manche: validity and outcome.
module morra_manche_judge
   import morra_pkg::*;
#(
   parameter int unsigned NO_REPEAT = 1
) (
   input  logic [1:0] primo,
   input  logic [1:0] secondo,
   input  vietata_t   vietata,
   output logic       valid_c,
   output logic [1:0] result_c
);

   logic repeat_hit;

   // Reject empty moves and a replay of the forbidden winning move, then score.
   always_comb begin
      valid_c    = 1'b0;
      result_c   = RIS_NULLO;
      repeat_hit = vietata.valid &&
                   (vietata.p2 ? (secondo == vietata.mossa) : (primo == vietata.mossa));
      if ((primo != MOSSA_NULLA) && (secondo != MOSSA_NULLA) &&
          !((NO_REPEAT != 0) && repeat_hit)) begin
         valid_c = 1'b1;
         if (batte(primo, secondo))
            result_c = RIS_PRIMO;
         else if (batte(secondo, primo))
            result_c = RIS_SECONDO;
         else
            result_c = RIS_PAREGGIO;
      end
   end

endmodule

// File: rtl/morra_cinese_match.sv
// Two-player rock-paper-scissors match engine: FSM, scoring, end detection, tallies.
module morra_cinese_match
   import morra_pkg::*;
#(
   parameter  int unsigned MIN_MANCHE = 4,
   parameter  int unsigned CFG_W      = 4,
   parameter  int unsigned WIN_MARGIN = 2,
   parameter  int unsigned NO_REPEAT  = 1,
   parameter  int unsigned VIT_W      = 8,
   localparam int unsigned MAX_TOT    = MIN_MANCHE + 2**CFG_W - 1,
   localparam int unsigned CNT_W      = $clog2(MAX_TOT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             INIZIA,
   input  logic [1:0]       PRIMO,
   input  logic [1:0]       SECONDO,
   output logic [1:0]       MANCHE,
   output logic [1:0]       PARTITA,
   output logic [CNT_W-1:0] N_MANCHE,
   output logic [CNT_W-1:0] PUNTI_PRIMO,
   output logic [CNT_W-1:0] PUNTI_SECONDO,
   output logic [VIT_W-1:0] VITTORIE_PRIMO,
   output logic [VIT_W-1:0] VITTORIE_SECONDO
);

   state_t             state_q, state_d;
   vietata_t           vietata_q, vietata_d;
   logic [CNT_W-1:0]   max_q, max_d;
   logic [CNT_W-1:0]   n_d, p1_d, p2_d, diff;
   logic [1:0]         manche_d, partita_d;
   logic [VIT_W-1:0]   v1_d, v2_d;
   logic [3:0]         mosse;
   logic [CFG_W-1:0]   cfg;
   logic               valid_c;
   logic [1:0]         result_c;
   logic               fine;

   assign mosse = {PRIMO, SECONDO};
   assign cfg   = mosse[CFG_W-1:0];

   morra_manche_judge #(
      .NO_REPEAT (NO_REPEAT)
   ) u_judge (
      .primo    (PRIMO),
      .secondo  (SECONDO),
      .vietata  (vietata_q),
      .valid_c  (valid_c),
      .result_c (result_c)
   );

   // Next-state, scoring and end-of-match decision.
   always_comb begin
      state_d   = state_q;
      vietata_d = vietata_q;
      max_d     = max_q;
      n_d       = N_MANCHE;
      p1_d      = PUNTI_PRIMO;
      p2_d      = PUNTI_SECONDO;
      manche_d  = RIS_NULLO;
      partita_d = PARTITA;
      v1_d      = VITTORIE_PRIMO;
      v2_d      = VITTORIE_SECONDO;
      diff      = '0;
      fine      = 1'b0;

      if (INIZIA) begin
         max_d     = CNT_W'(MIN_MANCHE) + CNT_W'(cfg);
         n_d       = '0;
         p1_d      = '0;
         p2_d      = '0;
         partita_d = RIS_NULLO;
         vietata_d = '0;
         state_d   = PLAY;
      end else begin
         unique case (state_q)
            PLAY: begin
               if (valid_c) begin
                  manche_d = result_c;
                  n_d      = N_MANCHE + CNT_W'(1);
                  unique case (result_c)
                     RIS_PRIMO: begin
                        p1_d      = PUNTI_PRIMO + CNT_W'(1);
                        vietata_d = '{valid: 1'b1, p2: 1'b0, mossa: PRIMO};
                     end
                     RIS_SECONDO: begin
                        p2_d      = PUNTI_SECONDO + CNT_W'(1);
                        vietata_d = '{valid: 1'b1, p2: 1'b1, mossa: SECONDO};
                     end
                     default: vietata_d = '0;
                  endcase
                  diff = (p1_d > p2_d) ? (p1_d - p2_d) : (p2_d - p1_d);
                  fine = ((n_d >= CNT_W'(MIN_MANCHE)) && (diff >= CNT_W'(WIN_MARGIN))) ||
                         (n_d == max_q);
                  if (fine) begin
                     state_d = DONE;
                     if (p1_d > p2_d) begin
                        partita_d = RIS_PRIMO;
                        v1_d = (VITTORIE_PRIMO == '1) ? VITTORIE_PRIMO
                                                      : VITTORIE_PRIMO + VIT_W'(1);
                     end else if (p2_d > p1_d) begin
                        partita_d = RIS_SECONDO;
                        v2_d = (VITTORIE_SECONDO == '1) ? VITTORIE_SECONDO
                                                        : VITTORIE_SECONDO + VIT_W'(1);
                     end else begin
                        partita_d = RIS_PAREGGIO;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State, configuration and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         vietata_q        <= '0;
         max_q            <= CNT_W'(MIN_MANCHE);
         MANCHE           <= RIS_NULLO;
         PARTITA          <= RIS_NULLO;
         N_MANCHE         <= '0;
         PUNTI_PRIMO      <= '0;
         PUNTI_SECONDO    <= '0;
         VITTORIE_PRIMO   <= '0;
         VITTORIE_SECONDO <= '0;
      end else begin
         state_q          <= state_d;
         vietata_q        <= vietata_d;
         max_q            <= max_d;
         MANCHE           <= manche_d;
         PARTITA          <= partita_d;
         N_MANCHE         <= n_d;
         PUNTI_PRIMO      <= p1_d;
         PUNTI_SECONDO    <= p2_d;
         VITTORIE_PRIMO   <= v1_d;
         VITTORIE_SECONDO <= v2_d;
      end
   end

endmodule

// File: tb/tb_morra_cinese_match.sv
// Directed bench for morra_cinese_match; a second instance with 2-bit tallies checks saturation.
module tb_morra_cinese_match;
   import morra_pkg::*;

   localparam int unsigned CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             inizia;
   logic [1:0]       primo, secondo;

   logic [1:0]       manche, partita, manche_s, partita_s;
   logic [CNT_W-1:0] n_manche, punti_p, punti_s;
   logic [CNT_W-1:0] n_manche_s, punti_p_s, punti_s_s;
   logic [7:0]       vit_p, vit_s;
   logic [1:0]       vit_p_sat, vit_s_sat;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   morra_cinese_match dut (
      .clk              (clk),
      .rst              (rst),
      .INIZIA           (inizia),
      .PRIMO            (primo),
      .SECONDO          (secondo),
      .MANCHE           (manche),
      .PARTITA          (partita),
      .N_MANCHE         (n_manche),
      .PUNTI_PRIMO      (punti_p),
      .PUNTI_SECONDO    (punti_s),
      .VITTORIE_PRIMO   (vit_p),
      .VITTORIE_SECONDO (vit_s)
   );

   morra_cinese_match #(.VIT_W(2)) dut_sat (
      .clk              (clk),
      .rst              (rst),
      .INIZIA           (inizia),
      .PRIMO            (primo),
      .SECONDO          (secondo),
      .MANCHE           (manche_s),
      .PARTITA          (partita_s),
      .N_MANCHE         (n_manche_s),
      .PUNTI_PRIMO      (punti_p_s),
      .PUNTI_SECONDO    (punti_s_s),
      .VITTORIE_PRIMO   (vit_p_sat),
      .VITTORIE_SECONDO (vit_s_sat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] m, input logic [1:0] pa,
                          input int n, input int a, input int b);
      chk({tag, ".manche"},  32'(manche),   32'(m));
      chk({tag, ".partita"}, 32'(partita),  32'(pa));
      chk({tag, ".n"},       32'(n_manche), 32'(n));
      chk({tag, ".p1"},      32'(punti_p),  32'(a));
      chk({tag, ".p2"},      32'(punti_s),  32'(b));
      chk({tag, ".sat.manche"},  32'(manche_s),   32'(m));
      chk({tag, ".sat.partita"}, 32'(partita_s),  32'(pa));
      chk({tag, ".sat.n"},       32'(n_manche_s), 32'(n));
      chk({tag, ".sat.p1"},      32'(punti_p_s),  32'(a));
      chk({tag, ".sat.p2"},      32'(punti_s_s),  32'(b));
   endtask

   task automatic chk_vit(input string tag, input int v1, input int v2,
                          input int v1s, input int v2s);
      chk({tag, ".vit1"},     32'(vit_p),     32'(v1));
      chk({tag, ".vit2"},     32'(vit_s),     32'(v2));
      chk({tag, ".sat.vit1"}, 32'(vit_p_sat), 32'(v1s));
      chk({tag, ".sat.vit2"}, 32'(vit_s_sat), 32'(v2s));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic play(input logic [1:0] a, input logic [1:0] b);
      inizia  = 1'b0;
      primo   = a;
      secondo = b;
      tick();
   endtask

   task automatic start(input logic [3:0] cfg);
      inizia  = 1'b1;
      primo   = cfg[3:2];
      secondo = cfg[1:0];
      tick();
      inizia  = 1'b0;
      primo   = MOSSA_NULLA;
      secondo = MOSSA_NULLA;
   endtask

   initial begin
      rst = 1'b1; inizia = 1'b0; primo = 2'b00; secondo = 2'b00;
      tick(); tick();
      chk_out("reset", 2'b00, 2'b00, 0, 0, 0);
      chk_vit("reset", 0, 0, 0, 0);
      rst = 1'b0;

      // T1: max 4, two P1 wins, a draw, then the deciding win
      start(4'b0000);
      chk_out("t1.start", 2'b00, 2'b00, 0, 0, 0);
      play(SASSO, FORBICE);
      chk_out("t1.m1", 2'b01, 2'b00, 1, 1, 0);
      play(CARTA, SASSO);
      chk_out("t1.m2", 2'b01, 2'b00, 2, 2, 0);
      play(FORBICE, FORBICE);
      chk_out("t1.m3", 2'b11, 2'b00, 3, 2, 0);
      play(SASSO, FORBICE);
      chk_out("t1.m4", 2'b01, 2'b01, 4, 3, 0);
      chk_vit("t1.end", 1, 0, 1, 0);

      // T2: no-repeat rule, empty move, end at max with a 1-point lead
      start(4'b0000);
      play(SASSO, FORBICE);
      chk_out("t2.win", 2'b01, 2'b00, 1, 1, 0);
      play(SASSO, FORBICE);
      chk_out("t2.repeat", 2'b00, 2'b00, 1, 1, 0);
      play(CARTA, SASSO);
      chk_out("t2.newmove", 2'b01, 2'b00, 2, 2, 0);
      play(CARTA, CARTA);
      chk_out("t2.repeat_draw", 2'b00, 2'b00, 2, 2, 0);
      play(MOSSA_NULLA, SASSO);
      chk_out("t2.null", 2'b00, 2'b00, 2, 2, 0);
      play(SASSO, CARTA);
      chk_out("t2.p2win", 2'b10, 2'b00, 3, 2, 1);
      play(FORBICE, CARTA);
      chk_out("t2.p2repeat", 2'b00, 2'b00, 3, 2, 1);
      play(FORBICE, FORBICE);
      chk_out("t2.maxend", 2'b11, 2'b01, 4, 2, 1);
      chk_vit("t2.end", 2, 0, 2, 0);

      // T4: DONE ignores moves and freezes results; INIZIA clears but keeps tallies
      for (int i = 0; i < 3; i++) begin
         play(SASSO, FORBICE);
         chk_out("t4.done", 2'b00, 2'b01, 4, 2, 1);
      end
      chk_vit("t4.done", 2, 0, 2, 0);
      start(4'b0000);
      chk_out("t4.restart", 2'b00, 2'b00, 0, 0, 0);
      chk_vit("t4.restart", 2, 0, 2, 0);

      // T5: rst beats INIZIA; IDLE ignores moves; INIZIA mid-play restarts
      play(SASSO, FORBICE);
      chk_out("t5.play", 2'b01, 2'b00, 1, 1, 0);
      rst = 1'b1; inizia = 1'b1; primo = FORBICE; secondo = FORBICE;
      tick();
      rst = 1'b0; inizia = 1'b0;
      chk_out("t5.rst", 2'b00, 2'b00, 0, 0, 0);
      chk_vit("t5.rst", 0, 0, 0, 0);
      play(SASSO, FORBICE);
      chk_out("t5.idle", 2'b00, 2'b00, 0, 0, 0);
      start(4'b0000);
      play(SASSO, FORBICE);
      chk_out("t5.play2", 2'b01, 2'b00, 1, 1, 0);
      start(4'b0000);
      chk_out("t5.restart", 2'b00, 2'b00, 0, 0, 0);
      chk_vit("t5.restart", 0, 0, 0, 0);
      play(SASSO, FORBICE);
      chk_out("t5.forb_cleared", 2'b01, 2'b00, 1, 1, 0);

      // T3: max 19, alternating wins end 10/9 by length
      start(4'b1111);
      for (int i = 0; i < 19; i++) begin
         if (i % 2 == 0) play(SASSO, FORBICE);
         else            play(FORBICE, SASSO);
         if (i == 17) chk_out("t3.m18", 2'b10, 2'b00, 18, 9, 9);
      end
      chk_out("t3.m19", 2'b01, 2'b01, 19, 10, 9);
      chk_vit("t3.alt", 1, 0, 1, 0);

      // T3: draw-heavy run with equal scores ends in a draw
      start(4'b1111);
      play(SASSO, FORBICE);
      play(FORBICE, SASSO);
      for (int i = 0; i < 17; i++) play(CARTA, CARTA);
      chk_out("t3.draw", 2'b11, 2'b11, 19, 1, 1);
      chk_vit("t3.draw", 1, 0, 1, 0);

      // T6: P2 wins 5 matches by early margin (max 7); 2-bit tally saturates at 3
      for (int k = 1; k <= 5; k++) begin
         start(4'b0011);
         play(FORBICE, SASSO);
         play(SASSO, CARTA);
         play(CARTA, FORBICE);
         if (k == 1) chk_out("t6.m3", 2'b10, 2'b00, 3, 0, 3);
         play(FORBICE, SASSO);
         chk_out("t6.end", 2'b10, 2'b10, 4, 0, 4);
         chk_vit("t6.vit", 1, k, 1, (k > 3) ? 3 : k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
